shift_issue: RTL and testbench

SHIFT_ISSUE -- requirements
Module: shift_issue

---
 rtl/shift_issue.sv | 95 +++++++++
 tb/tb_shift_issue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_issue.sv
// shift_issue: decodes RV32I shift instructions and issues them through a 2-entry FIFO
module shift_issue #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      rs1_val,
    input  logic [31:0]      rs2_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_a,
    output logic [4:0]       out_shamt,
    output logic [1:0]       out_type,
    output logic [4:0]       out_rd,
    output logic             illegal,
    output logic [CNT_W-1:0] issue_count
);
    logic [31:0] mem_a  [2];
    logic [4:0]  mem_sh [2];
    logic [1:0]  mem_ty [2];
    logic [4:0]  mem_rd [2];
    logic        wptr, rptr;
    logic [1:0]  occ;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        is_op, is_shift, f7_zero, f7_alt, legal, acc, push, pop;
    logic [1:0]  ty;
    logic [4:0]  sh;

    assign f3       = instr[14:12];
    assign f7       = instr[31:25];
    assign is_op    = instr[6:0] == 7'b0110011;
    assign is_shift = is_op || instr[6:0] == 7'b0010011;
    assign f7_zero  = f7 == 7'b0000000;
    assign f7_alt   = f7 == 7'b0100000;
    assign in_ready = ~occ[1];
    assign out_valid = |occ;
    assign acc      = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign out_a     = mem_a[rptr];
    assign out_shamt = mem_sh[rptr];
    assign out_type  = mem_ty[rptr];
    assign out_rd    = mem_rd[rptr];

    // decode shift kind, legality and shift amount of the offered instruction
    always_comb begin
        legal = is_shift && ((f3 == 3'b001 && f7_zero) || (f3 == 3'b101 && (f7_zero || f7_alt)));
        ty    = f3 == 3'b001 ? 2'b01 : f7_alt ? 2'b10 : 2'b00;
        sh    = is_op ? rs2_val[4:0] : instr[24:20];
        push  = acc && legal && !flush;
    end

    // FIFO storage, pointers, occupancy, illegal pulse and handshake counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ         <= '0;
            wptr        <= 1'b0;
            rptr        <= 1'b0;
            illegal     <= 1'b0;
            issue_count <= '0;
            mem_a[0]    <= '0;
            mem_a[1]    <= '0;
            mem_sh[0]   <= '0;
            mem_sh[1]   <= '0;
            mem_ty[0]   <= '0;
            mem_ty[1]   <= '0;
            mem_rd[0]   <= '0;
            mem_rd[1]   <= '0;
        end else begin
            illegal <= acc && !legal && !flush;
            if (pop)
                issue_count <= issue_count + CNT_W'(1);
            if (flush) begin
                occ  <= '0;
                wptr <= 1'b0;
                rptr <= 1'b0;
            end else begin
                if (push) begin
                    mem_a[wptr]  <= rs1_val;
                    mem_sh[wptr] <= sh;
                    mem_ty[wptr] <= ty;
                    mem_rd[wptr] <= instr[11:7];
                    wptr         <= ~wptr;
                end
                if (pop)
                    rptr <= ~rptr;
                occ <= occ + 2'(push) - 2'(pop);
            end
        end
    end
endmodule

// File: tb/tb_shift_issue.sv
// tb_shift_issue: scoreboard bench for the shift issue FIFO
module tb_shift_issue;
    localparam int W = 4;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  sh;
        logic [1:0]  ty;
        logic [4:0]  rd;
    } op_t;

    typedef struct packed {
        logic       ok;
        logic [1:0] ty;
        logic [4:0] sh;
    } dec_t;

    logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0]   instr = '0, rs1_val = '0, rs2_val = '0;
    logic          in_ready, out_valid, illegal;
    logic [31:0]   out_a;
    logic [4:0]    out_shamt, out_rd;
    logic [1:0]    out_type;
    logic [W-1:0]  issue_count;

    int     n_chk = 0, n_fail = 0;
    op_t    q[$];
    logic [W-1:0] cnt = '0;
    logic   exp_ill = 1'b0;
    logic   clr_model = 1'b0;

    shift_issue #(.CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val), .out_valid(out_valid),
        .out_ready(out_ready), .out_a(out_a), .out_shamt(out_shamt), .out_type(out_type),
        .out_rd(out_rd), .illegal(illegal), .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {f7, r2, r1, f3, rd, opc};
    endfunction

    function automatic dec_t dec(input logic [31:0] i, input logic [31:0] b);
        dec_t d;
        d.ok = 1'b0;
        d.ty = 2'b00;
        d.sh = (i[6:0] == 7'h33) ? b[4:0] : i[24:20];
        if (i[6:0] == 7'h33 || i[6:0] == 7'h13) begin
            if (i[14:12] == 3'd1 && i[31:25] == 7'h00) begin d.ok = 1'b1; d.ty = 2'b01; end
            else if (i[14:12] == 3'd5 && i[31:25] == 7'h00) begin d.ok = 1'b1; d.ty = 2'b00; end
            else if (i[14:12] == 3'd5 && i[31:25] == 7'h20) begin d.ok = 1'b1; d.ty = 2'b10; end
        end
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] f7s [3];
        logic [2:0] f3s [3];
        logic [6:0] ops [3];
        f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h10;
        f3s[0] = 3'd1;  f3s[1] = 3'd5;  f3s[2] = 3'd0;
        ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03;
        return enc(f7s[$urandom_range(0, 2)], 5'($urandom), 5'($urandom), f3s[$urandom_range(0, 2)],
                   5'($urandom), ops[$urandom_range(0, 2)]);
    endfunction

    // compare outputs against the model, then advance the model to the next edge
    always @(negedge clk) begin
        dec_t d;
        logic hs, acc;
        op_t o;
        if (clr_model || !rst_n) begin
            q.delete();
            cnt = '0;
            exp_ill = 1'b0;
            clr_model = 1'b0;
        end
        check("out_valid", out_valid, q.size() > 0);
        check("in_ready", in_ready, q.size() < 2);
        check("illegal", illegal, exp_ill);
        check("issue_count", issue_count, cnt);
        if (q.size() > 0) begin
            check("out_a", out_a, q[0].a);
            check("out_shamt", out_shamt, q[0].sh);
            check("out_type", out_type, q[0].ty);
            check("out_rd", out_rd, q[0].rd);
        end
        if (rst_n) begin
            d   = dec(instr, rs2_val);
            hs  = q.size() > 0 && out_ready;
            acc = in_valid && q.size() < 2;
            exp_ill = acc && !d.ok && !flush;
            if (hs) cnt = cnt + 1'b1;
            if (flush) q.delete();
            else begin
                if (hs) void'(q.pop_front());
                if (acc && d.ok) begin
                    o.a = rs1_val; o.sh = d.sh; o.ty = d.ty; o.rd = instr[11:7];
                    q.push_back(o);
                end
            end
        end
    end

    task automatic send(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        logic got;
        got = 1'b0;
        instr = i; rs1_val = a; rs2_val = b; in_valid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (in_ready) begin got = 1'b1; break; end
        end
        check("send_timeout", got, 1'b1);
        @(posedge clk); #1 in_valid = 1'b0;
    endtask

    task automatic pulse(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        instr = i; rs1_val = a; rs2_val = b; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] op1, op2, op3;
        op1 = enc(7'h00, 5'd7, 5'd6, 3'd1, 5'd5, 7'h33);
        op2 = enc(7'h00, 5'd9, 5'd8, 3'd5, 5'd10, 7'h13);
        op3 = enc(7'h20, 5'd3, 5'd4, 3'd5, 5'd11, 7'h33);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_count", issue_count, 0);
        check("rst_out_a", out_a, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        pulse(32'h40315133, 32'h80000000, 32'h00000024);
        check("sra_valid", out_valid, 1'b1);
        check("sra_type", out_type, 2'b10);
        check("sra_shamt", out_shamt, 5'd4);
        check("sra_a", out_a, 32'h80000000);
        check("sra_rd", out_rd, 5'd2);
        @(posedge clk); #1;
        check("sra_count", issue_count, 1);
        check("sra_drained", out_valid, 1'b0);
        pulse(32'h00509093, 32'h12345678, $urandom);
        check("slli_type", out_type, 2'b01);
        check("slli_shamt", out_shamt, 5'd5);
        check("slli_rd", out_rd, 5'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        fork
            begin
                send(op1, 32'hA1, 32'h1F);
                send(op2, 32'hA2, 32'h00);
                send(op3, 32'hA3, 32'h21);
            end
            begin
                repeat (4) @(posedge clk);
                #2;
                check("bp_in_ready", in_ready, 1'b0);
                check("bp_head", out_a, 32'hA1);
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        pulse(32'h00208033, 32'h1, 32'h2);
        check("add_illegal", illegal, 1'b1);
        check("add_no_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        check("add_illegal_end", illegal, 1'b0);
        pulse(enc(7'h10, 5'd3, 5'd1, 3'd1, 5'd4, 7'h13), 32'h5, 32'h6);
        check("badf7_illegal", illegal, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(op1, 32'hB1, 32'h2);
        send(op2, 32'hB2, 32'h3);
        instr = op3; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", out_valid, 1'b0);
        check("flush_ready", in_ready, 1'b1);
        check("flush_illegal", illegal, 1'b0);
        send(op1, 32'hC1, 32'h4);
        out_ready = 1'b1; flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        for (int i = 0; i < 300; i++) begin
            instr = rand_instr();
            rs1_val = $urandom; rs2_val = $urandom;
            in_valid = 1'($urandom_range(0, 1));
            out_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 15) == 0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 16; i++) send(op2, i, 32'h0);
        repeat (3) @(posedge clk);
        #1 check("wrap_count", issue_count, 0);
        send(op3, 32'hD3, 32'h7);
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(op1, 32'hE1, 32'h1);
        send(op2, 32'hE2, 32'h1);
        @(posedge clk); #1;
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_ready", in_ready, 1'b1);
        check("arst_illegal", illegal, 1'b0);
        check("arst_count", issue_count, 0);
        check("arst_a", out_a, 0);
        check("arst_shamt", out_shamt, 0);
        check("arst_type", out_type, 0);
        check("arst_rd", out_rd, 0);
        clr_model = 1'b1;
        #1 rst_n = 1'b1;
        pulse(op3, 32'hF3, 32'h2);
        check("post_rst_valid", out_valid, 1'b1);
        check("post_rst_a", out_a, 32'hF3);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
